// File: rtl/switch_debouncer_if.sv
// Switch debouncer signal bundle: raw switch in, debounced level and rise tick out.
interface switch_debouncer_if;
  logic sw;
  logic db_level;
  logic db_tick;

  modport master (output sw, input db_level, input db_tick);
  modport slave  (input sw, output db_level, output db_tick);
endinterface

// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop synchronizer feeding a four-state FSM with an
// N-bit down-counter that requires 2^N stable cycles before changing level.
module switch_debouncer #(
  parameter int unsigned N = 20
) (
  input  logic               clk,
  input  logic               reset,
  switch_debouncer_if.slave  dbif
);

  localparam int unsigned CW = N;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] q_q, q_d;
  logic          s1_q, s1_d;
  logic          sw_sync_q, sw_sync_d;
  logic          db_level_q, db_level_d;
  logic          db_tick_q, db_tick_d;

  // Synchronizer inputs: only sw_sync_q is seen by the state machine.
  always_comb begin
    s1_d      = dbif.sw;
    sw_sync_d = s1_q;
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    case (state_q)
      ZERO: begin
        if (sw_sync_q) begin
          state_d = WAIT1;
          q_d     = '1;
        end
      end
      WAIT1: begin
        if (!sw_sync_q) begin
          state_d = ZERO;
        end else if (q_q != '0) begin
          q_d = q_q - CW'(1);
        end else begin
          state_d = ONE;
        end
      end
      ONE: begin
        if (!sw_sync_q) begin
          state_d = WAIT0;
          q_d     = '1;
        end
      end
      WAIT0: begin
        if (sw_sync_q) begin
          state_d = ONE;
        end else if (q_q != '0) begin
          q_d = q_q - CW'(1);
        end else begin
          state_d = ZERO;
        end
      end
      default: begin
        state_d = ZERO;
        q_d     = '0;
      end
    endcase
    db_level_d = (state_d == ONE) || (state_d == WAIT0);
    db_tick_d  = (state_q == WAIT1) && (state_d == ONE);
  end

  // State, counter, synchronizer and output registers with async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ZERO;
      q_q        <= '0;
      s1_q       <= 1'b0;
      sw_sync_q  <= 1'b0;
      db_level_q <= 1'b0;
      db_tick_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      s1_q       <= s1_d;
      sw_sync_q  <= sw_sync_d;
      db_level_q <= db_level_d;
      db_tick_q  <= db_tick_d;
    end
  end

  assign dbif.db_level = db_level_q;
  assign dbif.db_tick  = db_tick_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with N=3 (8-cycle stability window).
module tb_switch_debouncer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  switch_debouncer_if dbif ();

  switch_debouncer #(.N(3)) dut (
    .clk   (clk),
    .reset (reset),
    .dbif  (dbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ev, et;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dbif.db_level !== 1'b0 || dbif.db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_async level=%b tick=%b expected 0/0", dbif.db_level, dbif.db_tick);
    end
    repeat (3) tick();
    checks++;
    if (dbif.db_level !== 1'b0 || dbif.db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_held level=%b tick=%b expected 0/0", dbif.db_level, dbif.db_tick);
    end
    #2 reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (dbif.db_level !== 1'b0 || dbif.db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_release level=%b tick=%b expected 0/0", dbif.db_level, dbif.db_tick);
    end
  endtask

  task automatic test_clean_press();
    logic ev, et;
    dbif.sw = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      tick();
      ev = (e >= 10);
      et = (e == 10);
      checks++;
      if (dbif.db_level !== ev || dbif.db_tick !== et) begin
        errors++;
        $display("FAIL clean_press edge=%0d level=%b tick=%b expected %b/%b", e, dbif.db_level, dbif.db_tick, ev, et);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic ev;
    for (int e = 0; e <= 14; e++) begin
      dbif.sw = (e == 1);
      tick();
      ev = (e < 12);
      checks++;
      if (dbif.db_level !== ev || dbif.db_tick !== 1'b0) begin
        errors++;
        $display("FAIL release_bounce edge=%0d level=%b tick=%b expected %b/0", e, dbif.db_level, dbif.db_tick, ev);
      end
    end
  endtask

  task automatic test_bounce_press();
    logic ev, et;
    for (int e = 0; e <= 18; e++) begin
      dbif.sw = (e >= 6) ? 1'b1 : ((e % 2) == 0);
      tick();
      ev = (e >= 16);
      et = (e == 16);
      checks++;
      if (dbif.db_level !== ev || dbif.db_tick !== et) begin
        errors++;
        $display("FAIL bounce_press edge=%0d level=%b tick=%b expected %b/%b", e, dbif.db_level, dbif.db_tick, ev, et);
      end
    end
  endtask

  task automatic test_clean_release();
    dbif.sw = 1'b0;
    repeat (14) tick();
    checks++;
    if (dbif.db_level !== 1'b0 || dbif.db_tick !== 1'b0) begin
      errors++;
      $display("FAIL clean_release level=%b tick=%b expected 0/0", dbif.db_level, dbif.db_tick);
    end
  endtask

  task automatic test_glitch();
    for (int e = 0; e <= 20; e++) begin
      dbif.sw = (e < 5);
      tick();
      checks++;
      if (dbif.db_level !== 1'b0 || dbif.db_tick !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge=%0d level=%b tick=%b expected 0/0", e, dbif.db_level, dbif.db_tick);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic ev, et;
    dbif.sw = 1'b1;
    for (int e = 0; e <= 6; e++) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (dbif.db_level !== 1'b0 || dbif.db_tick !== 1'b0 || dut.q_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_wait level=%b tick=%b q=%0d expected 0/0/0", dbif.db_level, dbif.db_tick, dut.q_q);
    end
    repeat (2) tick();
    #3 reset = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      ev = (e >= 10);
      et = (e == 10);
      checks++;
      if (dbif.db_level !== ev || dbif.db_tick !== et) begin
        errors++;
        $display("FAIL after_reset edge=%0d level=%b tick=%b expected %b/%b", e, dbif.db_level, dbif.db_tick, ev, et);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ev, et;
    int   ticks;
    ticks = 0;
    for (int e = 0; e <= 39; e++) begin
      dbif.sw = (e < 12) || (e >= 24);
      tick();
      ev = ((e >= 10) && (e < 22)) || (e >= 34);
      et = (e == 10) || (e == 34);
      if (dbif.db_tick === 1'b1) ticks++;
      checks++;
      if (dbif.db_level !== ev || dbif.db_tick !== et) begin
        errors++;
        $display("FAIL back_to_back edge=%0d level=%b tick=%b expected %b/%b", e, dbif.db_level, dbif.db_tick, ev, et);
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL back_to_back_count ticks=%0d expected 2", ticks);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    dbif.sw = 1'b0;
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_bounce_press();
    test_clean_release();
    test_glitch();
    test_reset_mid_wait();
    test_clean_release();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter N, default 20, giving the width of the stability counter in bits; legal range 2..32; the stability window is 2^N clock cycles.
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port sw  input  1  raw mechanical switch level, asynchronous to clk, may bounce.
REQ-005 The block SHALL have port db_level  output  1  debounced level; drives the downstream level-pattern tick detector.
REQ-006 The block SHALL have port db_tick  output  1  one-cycle pulse marking each 0->1 transition of db_level.

Function
REQ-007 sw SHALL pass through a two-flop synchronizer (s1, then sw_sync); sw_sync SHALL be the only form of sw used by the state machine.
REQ-008 The state machine SHALL have four states: ZERO, WAIT1, ONE, WAIT0, plus an N-bit down-counter q.
REQ-009 ZERO: if sw_sync=1, go to WAIT1 and load q with all ones; otherwise stay in ZERO, q unchanged.
REQ-010 WAIT1: if sw_sync=0, go to ZERO (glitch rejected, no tick); else if q!=0, decrement q and stay; else (q==0, sw_sync=1) go to ONE.
REQ-011 ONE: if sw_sync=0, go to WAIT0 and load q with all ones; otherwise stay.
REQ-012 WAIT0: if sw_sync=1, go to ONE (glitch rejected); else if q!=0, decrement q and stay; else (q==0, sw_sync=0) go to ZERO.
REQ-013 Unreachable state encodings SHALL transition to ZERO on the next edge with q loaded 0.
REQ-014 db_level SHALL be registered and equal 1 exactly when the state is ONE or WAIT0.
REQ-015 db_tick SHALL be registered and equal 1 for exactly the first cycle after a WAIT1->ONE transition; 0 at all other times, including WAIT0->ONE returns.
REQ-016 Rise latency: if sw is first sampled 1 at edge E0 and held, db_level and db_tick SHALL go high after edge E0+2^N+2; db_tick SHALL fall after edge E0+2^N+3.
REQ-017 Fall latency: if sw is first sampled 0 at edge F0 and held, db_level SHALL go low after edge F0+2^N+2; db_tick SHALL stay 0.
REQ-018 Any reversal of sw_sync during WAIT1 or WAIT0, even one cycle, SHALL abort the wait; a new wait SHALL restart q from all ones.
REQ-019 q SHALL never wrap: it SHALL not decrement below 0 and SHALL load only on ZERO->WAIT1 and ONE->WAIT0.
REQ-020 Two consecutive db_tick pulses SHALL be separated by at least 2^(N+1)+2 cycles.

Reset
REQ-021 While reset=0, asynchronously and regardless of clk: state=ZERO, q=0, s1=0, sw_sync=0, db_level=0, db_tick=0.
REQ-022 Reset asserted mid-wait or in ONE SHALL abandon the operation with no tick; after release the block SHALL behave as from power-up (sw held 1 gives rise per REQ-016, measured from the first edge after release).
REQ-023 Reset deassertion SHALL take effect on the first rising clk edge after reset returns to 1.

Verification (N=3, window 8 cycles)
REQ-024 Clean press: sw 0->1 sampled at edge 0, held -> db_level=1 and db_tick=1 after edge 10; db_tick=0 after edge 11; db_level stays 1.
REQ-025 Bounce on press: sw toggles 1,0,1,0 on alternate cycles for 6 cycles then holds 1 -> no db_tick during bounce; exactly one db_tick, 10 edges after the final 0->1 sample.
REQ-026 Short glitch: sw=1 for 5 cycles then 0 -> db_level and db_tick never assert; state returns to ZERO.
REQ-027 Release with bounce: from ONE, sw 1->0 with one 1-cycle return to 1, then held 0 -> db_level stays 1 throughout, falls 10 edges after the final 1->0 sample; no db_tick.
REQ-028 Reset mid-wait: sw held 1, reset=0 pulsed asynchronously at edge 6 -> db_level, db_tick, q immediately 0; after release, db_tick at release-edge+10.
REQ-029 Back-to-back: press, release, press each held 12 cycles -> exactly two db_tick pulses, each one cycle wide, db_level tracking each held level 10 edges late.
